runner_player_ctrl: RTL and testbench

Player vertical-motion controller for the runner game. Sits directly downstream of the single-controller gamepad decoder: consumes the level-type `a` (jump) and `down` (duck) button states plus a once-per-frame tick from the sync generator. Runs a per-frame jump/gravity state machine and produces the registered player position and event pulses consumed by the sprite renderer and the sound generator.

---
 rtl/runner_player_ctrl.sv | 160 ++++++++++++++++
 tb/tb_runner_player_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/runner_player_ctrl.sv
// Player vertical-motion controller: per-frame jump/gravity state machine
// producing the registered sprite row and take-off/landing event pulses.
module runner_player_ctrl #(
  parameter int GROUND_Y = 400,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1,
  parameter int JUMP_CUT = 3,
  parameter int MAX_H    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       jump_btn,
  input  logic       duck_btn,
  output logic [9:0] player_y,
  output logic       on_ground,
  output logic       ducking,
  output logic       jump_pulse,
  output logic       land_pulse
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_e;

  localparam logic        [9:0] GROUND_Y_U = 10'(GROUND_Y);
  localparam logic        [7:0] V0_H       = 8'(JUMP_V0);
  localparam logic        [7:0] MAX_H_U    = 8'(MAX_H);
  localparam logic signed [9:0] V0_S       = 10'(JUMP_V0);
  localparam logic signed [9:0] GRAV_S     = 10'(GRAVITY);
  localparam logic signed [9:0] CUT_S      = 10'(JUMP_CUT);
  localparam logic signed [9:0] MAX_H_S    = 10'(MAX_H);
  localparam logic signed [9:0] VEL_FLOOR  = -10'sd31;

  state_e             state_q, state_d;
  logic        [7:0]  height_q, height_d;
  logic signed [5:0]  vel_q, vel_d;
  logic               jump_prev_q, jump_prev_d;
  logic               jump_req_q, jump_req_d;
  logic               armed_q, armed_d;
  logic               ducking_q, ducking_d;
  logic               jump_pulse_q, jump_pulse_d;
  logic               land_pulse_q, land_pulse_d;
  logic        [9:0]  player_y_q, player_y_d;

  logic               jump_edge;
  logic               tick_en;
  logic signed [9:0]  vel_ext;
  logic signed [9:0]  v_eff;
  logic signed [9:0]  sum;
  logic signed [9:0]  v_next;

  always_comb begin
    // armed_q masks the first sample after reset so a button held through
    // reset release never counts as a fresh press.
    jump_edge   = jump_btn & ~jump_prev_q & armed_q;
    tick_en     = frame_tick & enable;
    jump_prev_d = jump_btn;
    armed_d     = 1'b1;

    jump_req_d = jump_req_q | jump_edge;
    if (!enable || frame_tick) begin
      jump_req_d = 1'b0;
    end

    vel_ext = {{4{vel_q[5]}}, vel_q};
    v_eff   = vel_ext;
    if (state_q == ST_RISE && !jump_btn && vel_ext > CUT_S) begin
      v_eff = CUT_S;
    end
    sum    = $signed({2'b00, height_q}) + v_eff;
    v_next = v_eff - GRAV_S;
    if (v_next < VEL_FLOOR) begin
      v_next = VEL_FLOOR;
    end

    state_d      = state_q;
    height_d     = height_q;
    vel_d        = vel_q;
    ducking_d    = ducking_q;
    jump_pulse_d = 1'b0;
    land_pulse_d = 1'b0;

    if (tick_en) begin
      case (state_q)
        ST_GROUND: begin
          if (jump_req_q || jump_edge) begin
            state_d      = ST_RISE;
            height_d     = V0_H;
            vel_d        = 6'(V0_S - GRAV_S);
            jump_pulse_d = 1'b1;
            ducking_d    = 1'b0;
          end else begin
            ducking_d = duck_btn;
          end
        end
        ST_RISE, ST_FALL: begin
          if (sum <= 0) begin
            state_d      = ST_GROUND;
            height_d     = 8'd0;
            vel_d        = 6'sd0;
            land_pulse_d = 1'b1;
            ducking_d    = 1'b0;
          end else if (sum > MAX_H_S) begin
            state_d  = ST_FALL;
            height_d = MAX_H_U;
            vel_d    = 6'sd0;
          end else begin
            height_d = sum[7:0];
            vel_d    = v_next[5:0];
            state_d  = (v_next > 0) ? ST_RISE : ST_FALL;
          end
        end
        default: begin
          state_d  = ST_GROUND;
          height_d = 8'd0;
          vel_d    = 6'sd0;
        end
      endcase
    end

    player_y_d = GROUND_Y_U - {2'b00, height_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GROUND;
      height_q     <= 8'd0;
      vel_q        <= 6'sd0;
      jump_prev_q  <= 1'b0;
      jump_req_q   <= 1'b0;
      armed_q      <= 1'b0;
      ducking_q    <= 1'b0;
      jump_pulse_q <= 1'b0;
      land_pulse_q <= 1'b0;
      player_y_q   <= GROUND_Y_U;
    end else begin
      state_q      <= state_d;
      height_q     <= height_d;
      vel_q        <= vel_d;
      jump_prev_q  <= jump_prev_d;
      jump_req_q   <= jump_req_d;
      armed_q      <= armed_d;
      ducking_q    <= ducking_d;
      jump_pulse_q <= jump_pulse_d;
      land_pulse_q <= land_pulse_d;
      player_y_q   <= player_y_d;
    end
  end

  assign player_y   = player_y_q;
  assign on_ground  = (state_q == ST_GROUND);
  assign ducking    = ducking_q;
  assign jump_pulse = jump_pulse_q;
  assign land_pulse = land_pulse_q;

endmodule

// File: tb/tb_runner_player_ctrl.sv
// Bench for runner_player_ctrl: vector table, directed jump scenarios and
// randomized buttons against a frame-level motion model (two parameter sets).
module tb_runner_player_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, enable, jump_btn, duck_btn;
  logic [9:0] y0, y1;
  logic       g0, g1, d0, d1, jp0, jp1, lp0, lp1;

  always #5 clk = ~clk;

  runner_player_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .jump_btn(jump_btn), .duck_btn(duck_btn), .player_y(y0), .on_ground(g0),
    .ducking(d0), .jump_pulse(jp0), .land_pulse(lp0)
  );

  runner_player_ctrl #(.JUMP_V0(31), .GRAVITY(1), .MAX_H(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .jump_btn(jump_btn), .duck_btn(duck_btn), .player_y(y1), .on_ground(g1),
    .ducking(d1), .jump_pulse(jp1), .land_pulse(lp1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model, one slot per instance (0: defaults, 1: ceiling).
  int p_v0[2]  = '{12, 31};
  int p_g[2]   = '{1, 1};
  int p_cut[2] = '{3, 3};
  int p_max[2] = '{255, 100};
  int m_h[2], m_vel[2], m_st[2];  // m_st: 0 standing, 1 rising, 2 falling
  bit m_duck[2], m_jp[2], m_lp[2];
  bit m_prev, m_req, m_armed;

  int         jp_cnt, lp_cnt, lp_cnt1;
  logic [9:0] fy, f1y;
  logic       fjp, flp, fg, f1lp;
  int         traj[26];
  int         land_f;

  typedef struct {
    logic       j, d, en, t;
    logic [9:0] y;
    logic       g, dk, jp, lp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_h[i] = 0; m_vel[i] = 0; m_st[i] = 0;
      m_duck[i] = 0; m_jp[i] = 0; m_lp[i] = 0;
    end
    m_prev = 0; m_req = 0; m_armed = 0;
  endtask

  task automatic model_frame(input int i, input bit take);
    int v, s;
    if (m_st[i] == 0) begin
      if (take) begin
        m_h[i] = p_v0[i]; m_vel[i] = p_v0[i] - p_g[i]; m_st[i] = 1;
        m_jp[i] = 1; m_duck[i] = 0;
      end else begin
        m_duck[i] = duck_btn;
      end
    end else begin
      v = m_vel[i];
      if (m_st[i] == 1 && !jump_btn && v > p_cut[i]) v = p_cut[i];
      s = m_h[i] + v;
      if (s <= 0) begin
        m_h[i] = 0; m_vel[i] = 0; m_st[i] = 0; m_lp[i] = 1; m_duck[i] = 0;
      end else if (s > p_max[i]) begin
        m_h[i] = p_max[i]; m_vel[i] = 0; m_st[i] = 2;
      end else begin
        m_h[i] = s;
        m_vel[i] = (v - p_g[i] < -31) ? -31 : v - p_g[i];
        m_st[i] = (m_vel[i] > 0) ? 1 : 2;
      end
    end
  endtask

  task automatic model_clock();
    bit edge_seen;
    edge_seen = jump_btn && !m_prev && m_armed;
    for (int i = 0; i < 2; i++) begin
      m_jp[i] = 0; m_lp[i] = 0;
      if (frame_tick && enable) model_frame(i, m_req || edge_seen);
    end
    if (!enable || frame_tick) m_req = 0;
    else if (edge_seen) m_req = 1;
    m_prev = jump_btn;
    m_armed = 1;
  endtask

  task automatic compare_model();
    check("model_dut0", 32'({y0, g0, d0, jp0, lp0}),
          32'({10'(400 - m_h[0]), m_st[0] == 0, m_duck[0], m_jp[0], m_lp[0]}));
    check("model_dut1", 32'({y1, g1, d1, jp1, lp1}),
          32'({10'(400 - m_h[1]), m_st[1] == 0, m_duck[1], m_jp[1], m_lp[1]}));
  endtask

  task automatic cycle(input bit t);
    frame_tick = t;
    model_clock();
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    jp_cnt  += int'(jp0);
    lp_cnt  += int'(lp0);
    lp_cnt1 += int'(lp1);
    compare_model();
  endtask

  task automatic frame();
    cycle(1'b1);
    fy = y0; fjp = jp0; flp = lp0; fg = g0; f1y = y1; f1lp = lp1;
    repeat (3) cycle(1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_y0", 32'(y0), 32'd400);
    check("rst_y1", 32'(y1), 32'd400);
    check("rst_flags0", 32'({g0, d0, jp0, lp0}), 32'b1000);
    check("rst_flags1", 32'({g1, d1, jp1, lp1}), 32'b1000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    jp_cnt = 0; lp_cnt = 0; lp_cnt1 = 0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd400, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd400, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd400, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd388, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd388, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd377, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'd377, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd367, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10'd367, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd364, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd362, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd361, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b1; frame_tick = 1'b0; enable = 1'b1; jump_btn = 1'b0; duck_btn = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // Vector table: duck, take-off with duck held, enable freeze, jump cut.
    for (int i = 0; i < 12; i++) begin
      jump_btn = vecs[i].j; duck_btn = vecs[i].d; enable = vecs[i].en;
      cycle(vecs[i].t);
      check($sformatf("vec%0d", i), 32'({y0, g0, d0, jp0, lp0}),
            32'({vecs[i].y, vecs[i].g, vecs[i].dk, vecs[i].jp, vecs[i].lp}));
    end

    // Full jump with the button held.
    jump_btn = 0; duck_btn = 0; enable = 1;
    apply_reset();
    cycle(0);
    jump_btn = 1;
    cycle(0);
    for (int f = 1; f <= 25; f++) begin
      frame();
      traj[f] = 400 - m_h[0];
      if (f == 1) check("full_f1", 32'({fy, fjp}), 32'({10'd388, 1'b1}));
      if (f == 12) check("full_peak", 32'(fy), 32'd322);
      if (f == 13) check("full_peak_hold", 32'(fy), 32'd322);
      if (f == 25) check("full_land", 32'({fy, flp, fg}), 32'({10'd400, 1'b1, 1'b1}));
    end
    check("full_land_once", 32'(lp_cnt), 32'd1);

    // Short jump: release after frame 3.
    jump_btn = 0;
    apply_reset();
    cycle(0);
    jump_btn = 1;
    cycle(0);
    repeat (3) frame();
    check("short_f3", 32'(fy), 32'd367);
    jump_btn = 0;
    frame();
    check("short_f4", 32'(fy), 32'd364);
    land_f = 0;
    for (int f = 5; f <= 40 && land_f == 0; f++) begin
      frame();
      if (flp) land_f = f;
    end
    check("short_land_frame", 32'(land_f), 32'd16);
    repeat (2) frame();
    check("short_land_once", 32'(lp_cnt), 32'd1);

    // Edge coincident with the tick.
    jump_btn = 0;
    apply_reset();
    cycle(0); cycle(0);
    jump_btn = 1;
    frame();
    check("edge_on_tick", 32'({fy, fjp}), 32'({10'd388, 1'b1}));

    // Edge one cycle after the tick waits for the next tick.
    jump_btn = 0;
    apply_reset();
    cycle(0);
    cycle(1);
    jump_btn = 1;
    cycle(0);
    check("late_edge_wait", 32'({y0, jp0}), 32'({10'd400, 1'b0}));
    cycle(0); cycle(0);
    frame();
    check("late_edge_take", 32'({fy, fjp}), 32'({10'd388, 1'b1}));

    // Two edges within a frame give one jump; an airborne edge is dropped.
    jump_btn = 0;
    apply_reset();
    cycle(0);
    jump_btn = 1; cycle(0);
    jump_btn = 0; cycle(0);
    jump_btn = 1; cycle(0);
    frame();
    check("double_edge_f1", 32'({fy, fjp}), 32'({10'd388, 1'b1}));
    frame();
    check("double_edge_f2", 32'(fy), 32'd377);
    frame();
    jump_btn = 0; cycle(0);
    jump_btn = 1; cycle(0);
    for (int f = 0; f < 60 && !g0; f++) frame();
    repeat (3) frame();
    check("air_edge_dropped", 32'({g0, jp_cnt[7:0]}), 32'({1'b1, 8'd1}));

    // Enable low for 10 ticks mid-jump freezes, then the trajectory resumes.
    jump_btn = 0;
    apply_reset();
    cycle(0);
    jump_btn = 1;
    cycle(0);
    for (int f = 1; f <= 5; f++) begin
      frame();
      check("freeze_pre", 32'(fy), 32'(traj[f]));
    end
    enable = 0;
    repeat (10) begin
      frame();
      check("freeze_hold", 32'({fy, fjp, flp}), 32'({10'(traj[5]), 2'b00}));
    end
    enable = 1;
    for (int f = 6; f <= 25; f++) begin
      frame();
      check("freeze_resume", 32'(fy), 32'(traj[f]));
    end
    check("freeze_land_once", 32'(lp_cnt), 32'd1);

    // Reset mid-air with the button held through release.
    jump_btn = 0;
    apply_reset();
    cycle(0);
    jump_btn = 1;
    cycle(0);
    repeat (5) frame();
    check("midair_airborne", 32'(fg), 32'd0);
    #2;
    apply_reset();
    repeat (4) frame();
    check("held_no_jump", 32'({g0, y0, jp_cnt[7:0]}), 32'({1'b1, 10'd400, 8'd0}));
    jump_btn = 0; cycle(0);
    jump_btn = 1; cycle(0);
    frame();
    check("repress_jump", 32'({fy, fjp}), 32'({10'd388, 1'b1}));

    // Ceiling on the second instance (V0 31, MAX_H 100).
    jump_btn = 0;
    apply_reset();
    cycle(0);
    jump_btn = 1;
    cycle(0);
    repeat (4) frame();
    check("ceil_clamp", 32'(f1y), 32'd300);
    frame();
    check("ceil_hold", 32'(f1y), 32'd300);
    frame();
    check("ceil_descend", 32'(f1y), 32'd301);
    land_f = 0;
    for (int f = 7; f <= 40 && land_f == 0; f++) begin
      frame();
      if (f1lp) land_f = f;
    end
    check("ceil_land_frame", 32'(land_f), 32'd19);
    check("ceil_land_once", 32'(lp_cnt1), 32'd1);

    // Randomized buttons, enable and tick spacing against the model.
    jump_btn = 0; duck_btn = 0; enable = 1;
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0) jump_btn = ~jump_btn;
      if ($urandom_range(0, 7) == 0) duck_btn = ~duck_btn;
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 699) == 0) apply_reset();
      else cycle($urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
